// File: rtl/tetris_pkg.sv
// Shared definitions for the falling-figure timing logic: BCD level decoding
// and the level-to-drop-period curve.
package tetris_pkg;

  localparam int PERIOD_MS_WIDTH = 11;
  localparam int LEVEL_WIDTH     = 7;

  // Two-digit BCD to 1..99; out-of-range digits saturate at 9 and level 0 plays as 1.
  function automatic logic [LEVEL_WIDTH-1:0] bcd2_to_level(input logic [7:0] bcd);
    logic [3:0]             tens;
    logic [3:0]             units;
    logic [LEVEL_WIDTH-1:0] lvl;
    tens  = (bcd[7:4] > 4'd9) ? 4'd9 : bcd[7:4];
    units = (bcd[3:0] > 4'd9) ? 4'd9 : bcd[3:0];
    lvl   = LEVEL_WIDTH'(tens) * LEVEL_WIDTH'(10) + LEVEL_WIDTH'(units);
    if (lvl == '0) lvl = LEVEL_WIDTH'(1);
    return lvl;
  endfunction

  // Linear speed-up per level with a floor. lvl is never 0, so lvl-1 cannot wrap,
  // and the reduction is compared before subtracting so nothing underflows.
  function automatic logic [PERIOD_MS_WIDTH-1:0] level_to_period_ms(
    input logic [LEVEL_WIDTH-1:0] lvl,
    input int unsigned            base_ms,
    input int unsigned            step_ms,
    input int unsigned            min_ms
  );
    int unsigned                drop_ms;
    logic [PERIOD_MS_WIDTH-1:0] period;
    drop_ms = (32'(lvl) - 32'd1) * step_ms;
    if (drop_ms >= base_ms - min_ms) period = PERIOD_MS_WIDTH'(min_ms);
    else                             period = PERIOD_MS_WIDTH'(base_ms - drop_ms);
    return period;
  endfunction

endpackage

// File: rtl/tetris_drop_timer_if.sv
// Game-side connection of the gravity timer.
interface tetris_drop_timer_if;
  import tetris_pkg::*;

  // No valid/ready here: level_changed_i, restart_i and drop_tick_o are single-cycle
  // pulses acted on the cycle they are high; pause_i and soft_drop_i are levels;
  // level_i is sampled every cycle.
  logic [7:0]                 level_i;
  logic                       level_changed_i;
  logic                       restart_i;
  logic                       pause_i;
  logic                       soft_drop_i;
  logic                       drop_tick_o;
  logic [PERIOD_MS_WIDTH-1:0] period_ms_o;

  modport master (
    output level_i, level_changed_i, restart_i, pause_i, soft_drop_i,
    input  drop_tick_o, period_ms_o
  );

  modport slave (
    input  level_i, level_changed_i, restart_i, pause_i, soft_drop_i,
    output drop_tick_o, period_ms_o
  );

endinterface

// File: rtl/tetris_ms_strobe.sv
// Millisecond prescaler with clear and hold; also usable for key auto-repeat.
module tetris_ms_strobe #(
  parameter int unsigned DIV = 25_000
) (
  input  logic clk,
  input  logic srst_i,
  input  logic clear_i,
  input  logic hold_i,
  output logic ms_stb_o
);

  localparam int unsigned   PW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  logic [PW-1:0] presc;

  always_ff @(posedge clk) begin
    if (srst_i || clear_i) begin
      presc <= '0;
    end else if (!hold_i) begin
      presc <= (presc == PRESC_MAX) ? '0 : presc + PW'(1);
    end
  end

  // Qualified so it only marks milliseconds that actually elapse.
  assign ms_stb_o = (presc == PRESC_MAX) && !hold_i && !clear_i;

endmodule

// File: rtl/tetris_drop_timer.sv
// Gravity timer: turns the BCD level into a drop period and emits one-cycle drop ticks,
// with soft drop, pause and restart on figure spawn or level change.
module tetris_drop_timer
  import tetris_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ         = 25_000_000,
  parameter int unsigned BASE_PERIOD_MS      = 1000,
  parameter int unsigned STEP_MS             = 50,
  parameter int unsigned MIN_PERIOD_MS       = 50,
  parameter int unsigned SOFT_DROP_PERIOD_MS = 30
) (
  input  logic                clk,
  input  logic                srst_i,
  tetris_drop_timer_if.slave  bus
);

  localparam int unsigned MAX_PERIOD_MS = (1 << PERIOD_MS_WIDTH) - 1;

  generate
    if (CLK_FREQ_HZ < 1000 || (CLK_FREQ_HZ % 1000) != 0) begin : g_bad_clk
      $error("CLK_FREQ_HZ must be a non-zero multiple of 1000");
    end
    if (BASE_PERIOD_MS > MAX_PERIOD_MS || SOFT_DROP_PERIOD_MS > MAX_PERIOD_MS) begin : g_bad_wide
      $error("drop periods must not exceed 2047 ms");
    end
    if (MIN_PERIOD_MS == 0 || SOFT_DROP_PERIOD_MS == 0 || MIN_PERIOD_MS > BASE_PERIOD_MS) begin : g_bad_range
      $error("periods must be non-zero and MIN_PERIOD_MS must not exceed BASE_PERIOD_MS");
    end
  endgenerate

  localparam logic [PERIOD_MS_WIDTH-1:0] BASE_MS = PERIOD_MS_WIDTH'(BASE_PERIOD_MS);
  localparam logic [PERIOD_MS_WIDTH-1:0] SOFT_MS = PERIOD_MS_WIDTH'(SOFT_DROP_PERIOD_MS);

  logic [LEVEL_WIDTH-1:0]     level;
  logic [PERIOD_MS_WIDTH-1:0] level_period;
  logic [PERIOD_MS_WIDTH-1:0] eff_period;
  logic [PERIOD_MS_WIDTH-1:0] period_q;
  logic [PERIOD_MS_WIDTH-1:0] ms_cnt;
  logic                       restart;
  logic                       ms_stb;
  logic                       terminal;
  logic                       drop_tick_q;

  assign level        = bcd2_to_level(bus.level_i);
  assign level_period = level_to_period_ms(level, BASE_PERIOD_MS, STEP_MS, MIN_PERIOD_MS);
  assign restart      = bus.restart_i || bus.level_changed_i;

  always_comb begin
    eff_period = level_period;
    if (bus.soft_drop_i && (SOFT_MS < level_period)) eff_period = SOFT_MS;
  end

  tetris_ms_strobe #(
    .DIV (CLK_FREQ_HZ / 1000)
  ) u_ms_strobe (
    .clk      (clk),
    .srst_i   (srst_i),
    .clear_i  (restart),
    .hold_i   (bus.pause_i),
    .ms_stb_o (ms_stb)
  );

  // >= rather than == so a period that shrinks under the running count fires on
  // the next millisecond instead of waiting for the counter to wrap.
  // ms_stb is already low during pause and restart, which suppresses the tick.
  assign terminal = ms_stb && (ms_cnt >= period_q - PERIOD_MS_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (srst_i) begin
      period_q    <= BASE_MS;
      ms_cnt      <= '0;
      drop_tick_q <= 1'b0;
    end else begin
      period_q    <= eff_period;
      drop_tick_q <= terminal;
      if (restart || terminal) begin
        ms_cnt <= '0;
      end else if (ms_stb) begin
        ms_cnt <= ms_cnt + PERIOD_MS_WIDTH'(1);
      end
    end
  end

  assign bus.drop_tick_o = drop_tick_q;
  assign bus.period_ms_o = period_q;

endmodule
